network_argmax: RTL
===================

# network_argmax

Downstream stage of `Network`. It consumes the output-layer stream (NO signed lanes of $clog2(NH1)+1+WF bits) together with a label stream carrying the teacher class index. It finds the winning lane by a sequential one-lane-per-cycle scan and emits {hit, index, max value}. It also keeps saturating total/hit counters for accuracy measurement in INFER and TRAIN runs.

## Interface
- NO, 2, number of output lanes (≥1)
- NH1, 3, last hidden layer size; sets lane width W = $clog2(NH1)+1+WF
- WF, 8, fraction/base width
- WC, 16, counter width
- BURST, "yes", "yes": a new input may be accepted in the same cycle the result is taken; "no": one idle cycle between results
- Derived: WI = (NO>1) ? $clog2(NO) : 1; WO = 1+WI+W

Ports:
- iCLK  in  1  clock
- iRST  in  1  reset, synchronous, active-high
- iValid_AM_Input  in  1  network output valid
- oReady_AM_Input  out  1  network output ready
- iData_AM_Input  in  NO*W  lane k at [k*W+:W], two's complement
- iValid_AM_Label  in  1  label valid
- oReady_AM_Label  out  1  label ready
- iData_AM_Label  in  WI  teacher class index
- oValid_BM_Result  out  1  result valid
- iReady_BM_Result  in  1  result ready
- oData_BM_Result  out  WO  {hit, index, max}; hit at MSB, max at [W-1:0]
- iClear  in  1  synchronous counter clear
- oCount_Total  out  WC  results delivered
- oCount_Hit  out  WC  results with hit=1

## Operation
- FSM states: IDLE, SCAN, EMIT.
- Join: accept fires only when both valids are high and the FSM can accept. oReady_AM_Input = oReady_AM_Label = can_accept & iValid_AM_Input & iValid_AM_Label.
- can_accept = (state==IDLE), or (state==EMIT & iReady_BM_Result & BURST=="yes").
- On accept: register all lanes and the label; max←lane 0; idx←0; ptr←1. Next state is SCAN if NO>1, else EMIT.
- SCAN: one lane per cycle. If signed lane[ptr] > max (strictly), max←lane[ptr] and idx←ptr. ptr increments. After lane NO-1, go to EMIT.
- Ties keep the lowest index.
- EMIT: oValid_BM_Result=1. Data is held stable until taken. hit = (idx == label).
- Labels ≥ NO never hit.
- On result handshake: oCount_Total+1 and oCount_Hit+hit, each saturating at all-ones. Next state is IDLE, or the accept path if a join fires in the same cycle (BURST="yes").
- iClear zeroes both counters. If it coincides with a result handshake, clear wins and that result is not counted. Clear does not touch the FSM.

## Timing
- Reset values: every output is 0. This covers oValid, oReady×2, oData, and both counters. State=IDLE.
- iRST in any state aborts the current item: no result is emitted, the counters are zeroed, and any held input is discarded.
- Latency: accept at cycle t gives oValid at t+NO.
- Throughput: one result per NO cycles with BURST="yes" and the sink always ready; one per NO+1 with "no".
- Ready signals are combinational from valids, state and iReady_BM_Result. No combinational path exists from the input data to any output.
- Sink backpressure holds EMIT indefinitely. Inputs stall with ready=0, and no data is lost or reordered.
- One valid without the other: neither side is accepted, and nothing is consumed.

## Test plan
- NO=2, NH1=3, WF=8 (W=11): lanes {k0=0x010, k1=0x020}, label 1 → after 2 cycles, result {1, 1, 0x020}; Total=1, Hit=1.
- Negative lanes: k0=0x7F0 (−16), k1=0x7F8 (−8), label 0 → {0, 1, 0x7F8}; Hit unchanged, Total+1.
- Tie: NO=4, all lanes 0x005, label 0 → index 0, hit=1.
- iReady_BM_Result low for 10 cycles, then high. Expect: oData stable throughout, ready signals low, exactly one count increment.
- 8 back-to-back items, BURST="yes", sink always ready → results every NO cycles. Same stream with BURST="no" → every NO+1 cycles.
- Raise iRST during SCAN → no result emitted; counters 0. iClear together with a result handshake → counters 0.
- Set WC=4 and run 20 hits → Total and Hit both saturate at 15.

Source files
------------

// File: rtl/network_argmax.sv
// network_argmax
// Output stage of the network pipeline. It joins one output-layer vector
// (NO signed lanes) with the matching teacher label. The lanes are scanned
// one per cycle to find the largest value, with ties going to the lowest
// index. The stage then emits {hit, index, max}. Two saturating counters
// record how many results were delivered and how many of them hit.
//
// Ports
//   iCLK, iRST          clock, synchronous active-high reset
//   iValid_AM_Input     network vector valid
//   oReady_AM_Input     network vector ready (joined with label)
//   iData_AM_Input      NO lanes of W bits, lane k at [k*W +: W]
//   iValid_AM_Label     label valid
//   oReady_AM_Label     label ready (joined with vector)
//   iData_AM_Label      teacher class index
//   oValid_BM_Result    result valid
//   iReady_BM_Result    result ready
//   oData_BM_Result     {hit, index, max}
//   iClear              synchronous counter clear
//   oCount_Total        results delivered (saturating)
//   oCount_Hit          results with hit set (saturating)
module network_argmax #(
  parameter int    NO    = 2,
  parameter int    NH1   = 3,
  parameter int    WF    = 8,
  parameter int    WC    = 16,
  parameter string BURST = "yes",
  localparam int   W     = $clog2(NH1) + 1 + WF,
  localparam int   WI    = (NO > 1) ? $clog2(NO) : 1,
  localparam int   WO    = 1 + WI + W
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iValid_AM_Input,
  output logic            oReady_AM_Input,
  input  logic [NO*W-1:0] iData_AM_Input,
  input  logic            iValid_AM_Label,
  output logic            oReady_AM_Label,
  input  logic [WI-1:0]   iData_AM_Label,
  output logic            oValid_BM_Result,
  input  logic            iReady_BM_Result,
  output logic [WO-1:0]   oData_BM_Result,
  input  logic            iClear,
  output logic [WC-1:0]   oCount_Total,
  output logic [WC-1:0]   oCount_Hit
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;

  // A single-lane vector has nothing to scan and goes straight to EMIT.
  localparam state_t          FIRST_STATE = (NO > 1) ? SCAN : EMIT;
  localparam bit              BURST_EN    = (BURST == "yes");
  localparam logic [WI-1:0]   LAST_PTR    = WI'(NO - 1);
  localparam logic [WC-1:0]   CNT_MAX     = {WC{1'b1}};

  state_t              state_r;
  state_t              state_nxt_s;
  logic signed [W-1:0] lanes_r [NO];
  logic signed [W-1:0] max_r;
  logic [WI-1:0]       idx_r;
  logic [WI-1:0]       ptr_r;
  logic [WI-1:0]       label_r;
  logic [WC-1:0]       total_r;
  logic [WC-1:0]       hit_cnt_r;
  logic                take_s;
  logic                can_accept_s;
  logic                accept_s;
  logic                last_s;
  logic                hit_s;

  // Handshake decode and next-state selection
  always_comb begin
    take_s       = 1'b0;
    can_accept_s = 1'b0;
    accept_s     = 1'b0;
    last_s       = 1'b0;
    state_nxt_s  = state_r;

    take_s       = (state_r == EMIT) && iReady_BM_Result;
    // In burst mode a new vector may enter in the same cycle the result leaves.
    can_accept_s = (state_r == IDLE) || (take_s && BURST_EN);
    accept_s     = can_accept_s && iValid_AM_Input && iValid_AM_Label;
    last_s       = (ptr_r == LAST_PTR);

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = FIRST_STATE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (last_s) begin
          state_nxt_s = EMIT;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      EMIT: begin
        if (accept_s) begin
          state_nxt_s = FIRST_STATE;
        end else if (take_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = EMIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture of the vector and label, then the one-lane-per-cycle max scan
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int k = 0; k < NO; k++) begin
        lanes_r[k] <= {W{1'b0}};
      end
      max_r   <= {W{1'b0}};
      idx_r   <= {WI{1'b0}};
      ptr_r   <= {WI{1'b0}};
      label_r <= {WI{1'b0}};
    end else if (accept_s) begin
      for (int k = 0; k < NO; k++) begin
        lanes_r[k] <= iData_AM_Input[k*W +: W];
      end
      max_r   <= iData_AM_Input[W-1:0];
      idx_r   <= {WI{1'b0}};
      ptr_r   <= WI'(1);
      label_r <= iData_AM_Label;
    end else if (state_r == SCAN) begin
      // Strict compare so an equal later lane never displaces an earlier one.
      if (lanes_r[ptr_r] > max_r) begin
        max_r <= lanes_r[ptr_r];
        idx_r <= ptr_r;
      end
      ptr_r <= ptr_r + WI'(1);
    end
  end

  // An out-of-range label can never equal a lane index, so it never hits.
  assign hit_s = (idx_r == label_r);

  // Saturating accuracy counters; clear takes priority over a result handshake
  always_ff @(posedge iCLK) begin
    if (iRST || iClear) begin
      total_r   <= {WC{1'b0}};
      hit_cnt_r <= {WC{1'b0}};
    end else if (take_s) begin
      if (total_r != CNT_MAX) begin
        total_r <= total_r + WC'(1);
      end
      if (hit_s && (hit_cnt_r != CNT_MAX)) begin
        hit_cnt_r <= hit_cnt_r + WC'(1);
      end
    end
  end

  assign oReady_AM_Input  = accept_s;
  assign oReady_AM_Label  = accept_s;
  assign oValid_BM_Result = (state_r == EMIT);
  // Result bus is driven only in EMIT so it reads zero out of reset and while idle.
  assign oData_BM_Result  = oValid_BM_Result ? {hit_s, idx_r, max_r} : {WO{1'b0}};
  assign oCount_Total     = total_r;
  assign oCount_Hit       = hit_cnt_r;

endmodule
